mem_access_unit: RTL
====================

# mem_access_unit

Load/store front-end between the MEM pipeline stage and the word-wide data memory. It accepts one byte-addressed load or store per cycle and converts it to word-indexed memory accesses. Loads return byte, halfword or word data with sign or zero extension. Sub-word stores are done as a two-cycle read-modify-write, during which the pipeline is stalled.

## Interface
Parameters:
- `WORD_IDX_BITS`, default 16: number of word-index bits driven to the memory.

Ports (`DATA_WIDTH` = 32, `MEM_ADDR_WIDTH` = 32, both from def.v):
- `clk_phase1_i` in 1: single clock. All state updates on its rising edge.
- `rst_i` in 1: reset. Synchronous, active-high.
- `req_valid_i` in 1: a request is present.
- `req_load_i` in 1: the request is a load.
- `req_store_i` in 1: the request is a store.
- `req_size_i` in 2: 00 byte, 01 halfword, 10 word; 11 is treated as word.
- `req_unsigned_i` in 1: zero-extend load data (otherwise sign-extend).
- `req_addr_i` in `MEM_ADDR_WIDTH`: byte address.
- `req_wdata_i` in `DATA_WIDTH`: store data, right-aligned.
- `stall_o` out 1: combinational. While high, upstream must hold all `req_*` unchanged.
- `resp_valid_q` out 1: registered. Load data is valid.
- `resp_data_q` out `DATA_WIDTH`: registered, extended load result.
- `misalign_q` out 1: registered, one-cycle pulse for a misaligned request.
- `mem_read_o` out 1: memory read enable.
- `mem_write_o` out 1: memory write enable.
- `mem_addr_o` out `MEM_ADDR_WIDTH`: word index, `{zeros, req_addr_i[WORD_IDX_BITS+1:2]}`.
- `mem_wdata_o` out `DATA_WIDTH`: memory write data.
- `mem_rdata_i` in `DATA_WIDTH`: memory read data. Combinational; high-Z when `mem_read_o` is 0.

## Operation
- Byte order is little-endian: lane k = addr[1:0] occupies bits 8k+7:8k. A halfword uses lanes {addr[1],0} and {addr[1],1}.
- Misalignment is a halfword with addr[0]=1, or a word with addr[1:0]≠0. A misaligned request:
  - raises no memory enable;
  - sets `misalign_q`=1 for one cycle;
  - leaves `resp_valid_q`=0;
  - does not stall.
- If `req_load_i` and `req_store_i` are both high, the request is handled as a store and no response is given.
- FSM states are IDLE and RMW_WR.
- IDLE, aligned load:
  - `mem_read_o`=1.
  - At the edge, the selected lanes of `mem_rdata_i` are extended into `resp_data_q` and `resp_valid_q`=1.
- IDLE, aligned word store: `mem_write_o`=1 and `mem_wdata_o`=`req_wdata_i`. Single cycle, no stall.
- IDLE, aligned byte or halfword store:
  - `mem_read_o`=1 and `stall_o`=1.
  - At the edge, the merged word (old word with the target lanes replaced by the low 8 or 16 bits of `req_wdata_i`) is registered, and the FSM goes to RMW_WR.
- RMW_WR:
  - `mem_write_o`=1, `mem_wdata_o`=merged word, `stall_o`=0.
  - The FSM returns to IDLE unconditionally.
  - The request still held on the inputs is ignored, not restarted.
- `resp_valid_q` and `misalign_q` are 0 in every cycle not described above.
- `mem_read_o` and `mem_write_o` are never both 1. When neither is 1, `mem_rdata_i` is never sampled.

## Timing
- Reset values: state IDLE, `resp_valid_q`=0, `resp_data_q`=0, `misalign_q`=0, merged register 0.
- While `rst_i`=1, `mem_read_o`, `mem_write_o` and `stall_o` are forced to 0.
- Reset asserted in RMW_WR aborts the write; the memory word is unchanged.
- Load latency: request in cycle N, data in `resp_data_q` during N+1.
- Word store: written at the edge ending cycle N.
- Sub-word store:
  - read in N with `stall_o`=1;
  - written at the edge ending N+1;
  - upstream advances after N+1.
- Back-to-back requests are allowed. A load directly after an RMW store, to the same word, sees the new data.
- Address bits above `WORD_IDX_BITS`+1 are ignored, so the address wraps modulo 2^(`WORD_IDX_BITS`+2) bytes.

## Test plan
- Word store 0xDEADBEEF to address 0x100, then unsigned word load from 0x100 -> `mem_addr_o`=0x40, `resp_data_q`=0xDEADBEEF one cycle after the load, no stall.
- Mem[0x40]=0x11223344; byte store 0xAA to 0x102 -> `stall_o`=1 for exactly one cycle, then write 0x11AA3344; a following word load returns 0x11AA3344.
- Mem word = 0x8000F07F:
  - signed byte load at offset 0 -> 0x0000007F;
  - signed byte load at offset 1 -> 0xFFFFFFF0;
  - unsigned halfword load at offset 2 -> 0x00008000;
  - signed halfword load at offset 2 -> 0xFFFF8000.
- Halfword load at 0x101 and word store at 0x102 -> `misalign_q`=1 for one cycle each, no memory enables, memory unchanged, `resp_valid_q`=0.
- Halfword store 0xBEEF to 0x200 with `rst_i` asserted during RMW_WR -> word unchanged; after reset, all outputs are 0 and the FSM is in IDLE.
- Store to 0x0004_0010 -> `mem_addr_o`=0x0004 (wrap-around).

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store front-end: byte-addressed requests to a word-wide memory, with
// sign/zero-extended loads and two-cycle read-modify-write for sub-word stores.
module mem_access_unit #(
    parameter int  WORD_IDX_BITS = 16,
    localparam int DATA_W        = 32,
    localparam int ADDR_W        = 32
) (
    input  logic              clk_phase1_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic              req_load_i,
    input  logic              req_store_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              stall_o,
    output logic              resp_valid_q,
    output logic [DATA_W-1:0] resp_data_q,
    output logic              misalign_q,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t            state;
    logic [DATA_W-1:0] merged_q;

    logic       is_store;
    logic       is_load;
    logic       is_half;
    logic       is_word;
    logic       misaligned;
    logic       in_idle;
    logic       load_go;
    logic       wstore_go;
    logic       rmw_go;
    logic       mis_go;
    logic [1:0] lane;
    logic       unused_addr;

    assign unused_addr = ^req_addr_i[ADDR_W-1:WORD_IDX_BITS+2];

    function automatic logic [DATA_W-1:0] extend_load(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        off,
        input logic [1:0]        size,
        input logic              uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] merge_store(
        input logic [DATA_W-1:0] old,
        input logic [DATA_W-1:0] wdata,
        input logic [1:0]        off,
        input logic [1:0]        size
    );
        logic [DATA_W-1:0] w;
        w = old;
        if (size == 2'b00)
            w[{off, 3'b000} +: 8] = wdata[7:0];
        else if (off[1])
            w[31:16] = wdata[15:0];
        else
            w[15:0] = wdata[15:0];
        return w;
    endfunction

    // Request decode; a load+store request is treated as a store.
    always_comb begin
        lane       = req_addr_i[1:0];
        is_store   = req_store_i;
        is_load    = req_load_i & ~req_store_i;
        is_half    = (req_size_i == 2'b01);
        is_word    = req_size_i[1];
        misaligned = (is_half & lane[0]) | (is_word & (lane != 2'b00));
        in_idle    = (state == IDLE);
        mis_go     = in_idle & req_valid_i & (is_load | is_store) & misaligned;
        load_go    = in_idle & req_valid_i & is_load & ~misaligned;
        wstore_go  = in_idle & req_valid_i & is_store & is_word & ~misaligned;
        rmw_go     = in_idle & req_valid_i & is_store & ~is_word & ~misaligned;
    end

    // Memory side is combinational; the held request supplies the address in RMW_WR.
    always_comb begin
        mem_addr_o  = {{(ADDR_W-WORD_IDX_BITS){1'b0}}, req_addr_i[WORD_IDX_BITS+1:2]};
        mem_read_o  = ~rst_i & (load_go | rmw_go);
        mem_write_o = ~rst_i & (wstore_go | (state == RMW_WR));
        stall_o     = ~rst_i & rmw_go;
        mem_wdata_o = (state == RMW_WR) ? merged_q : req_wdata_i;
    end

    always_ff @(posedge clk_phase1_i) begin
        if (rst_i) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            misalign_q   <= 1'b0;
            merged_q     <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (mis_go) begin
                        misalign_q <= 1'b1;
                    end else if (load_go) begin
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= extend_load(mem_rdata_i, lane, req_size_i, req_unsigned_i);
                    end else if (rmw_go) begin
                        merged_q <= merge_store(mem_rdata_i, req_wdata_i, lane, req_size_i);
                        state    <= RMW_WR;
                    end
                end
                RMW_WR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
